// File: rtl/seg_display_ctrl.sv
// Debounced snapshot of a 32-bit result word, shown as 8 hex digits
// on a multiplexed common-anode 7-segment display.
module seg_display_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_CYCLES  = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_btn_enable_d_s_o,
  input  logic [31:0] i_data,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          prev_q, prev_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic          valid_q, valid_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    sync1_d  = i_btn_enable_d_s_o;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = ~db_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    prev_d  = db_q;
    word_d  = word_q;
    valid_d = valid_q;
    if (db_q && !prev_q) begin
      word_d  = i_data;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    ref_cnt_d = ref_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (ref_cnt_q == RF_LAST) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + 3'd1;
    end
    nib   = word_q[{idx_q, 2'b00} +: 4];
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    if (valid_q) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = hex7(nib);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_cnt_q  <= '0;
      prev_q    <= 1'b0;
      ref_cnt_q <= '0;
      idx_q     <= 3'd0;
      word_q    <= 32'h0;
      valid_q   <= 1'b0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_cnt_q  <= db_cnt_d;
      prev_q    <= prev_d;
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign o_an         = an_q;
  assign o_seg        = seg_q;
  assign o_dp         = 1'b1;
  assign o_word_valid = valid_q;
  assign o_word       = word_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomized and directed bench for seg_display_ctrl against a
// window-based debounce and timeline-based scan reference model.
module tb_seg_display_ctrl;

  localparam int DC = 4;
  localparam int RC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic [31:0] data;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        wvalid;
  logic [31:0] word;

  int errs = 0;
  int checks = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                               7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state
  logic [31:0] m_word;
  logic        m_valid;
  logic        m_db;
  logic        m_rose;
  int          m_k;
  logic        p1, p2;
  logic        win[$];
  logic [7:0]  m_an;
  logic [6:0]  m_seg;

  seg_display_ctrl #(.DEBOUNCE_CYCLES(DC), .REFRESH_CYCLES(RC)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_btn_enable_d_s_o(btn),
    .i_data(data),
    .o_an(an),
    .o_seg(seg),
    .o_dp(dp),
    .o_word_valid(wvalid),
    .o_word(word)
  );

  always #5 clk = ~clk;

  // One clock edge: advance the model with the inputs present at the edge.
  task automatic tick();
    int  idx;
    logic s;
    logic all_diff;
    if (rst) begin
      m_word = 0; m_valid = 0; m_db = 0; m_rose = 0; m_k = 0;
      p1 = 0; p2 = 0; win.delete();
      m_an = 8'hFF; m_seg = 7'h7F;
    end else begin
      idx = (m_k / RC) % 8;
      m_an = m_valid ? ~(8'h01 << idx) : 8'hFF;
      m_seg = m_valid ? hex_tab[m_word[4*idx +: 4]] : 7'h7F;
      if (m_rose) begin
        m_word = data;
        m_valid = 1;
      end
      m_rose = 0;
      s = p2; p2 = p1; p1 = btn;
      win.push_back(s);
      if (win.size() > DC) void'(win.pop_front());
      all_diff = (win.size() == DC);
      foreach (win[i]) if (win[i] == m_db) all_diff = 0;
      if (all_diff) begin
        m_db = ~m_db;
        m_rose = m_db;
        win.delete();
      end
      m_k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    checks++;
    if (word !== m_word || wvalid !== m_valid || an !== m_an ||
        seg !== m_seg || dp !== 1'b1) begin
      errs++;
      $display("FAIL %s: got word=%h v=%b an=%h seg=%h dp=%b want word=%h v=%b an=%h seg=%h dp=1",
               tag, word, wvalid, an, seg, dp, m_word, m_valid, m_an, m_seg);
    end
  endtask

  task automatic test_reset();
    rst = 1; btn = 0; data = 32'hFFFF_FFFF;
    tick(); tick();
    checks++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 ||
        wvalid !== 1'b0 || word !== 32'h0) begin
      errs++;
      $display("FAIL reset_state: an=%h seg=%h dp=%b v=%b word=%h want FF 7F 1 0 0",
               an, seg, dp, wvalid, word);
    end
    for (int i = 0; i < 16; i++) begin
      btn = (i % 5) < 3;
      tick();
      checks++;
      if (wvalid !== 1'b0 || word !== 32'h0 || an !== 8'hFF) begin
        errs++;
        $display("FAIL reset_hold: v=%b word=%h an=%h want 0 0 FF", wvalid, word, an);
      end
    end
    btn = 0;
    tick();
  endtask

  task automatic test_clean_press();
    rst = 0; btn = 0; data = 32'h1234_ABCD;
    tick(); tick(); tick();
    btn = 1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      cmp_model("clean_model");
      if (e == 5) begin
        checks++;
        if (wvalid !== 1'b0) begin
          errs++;
          $display("FAIL clean_edge5: v=%b want 0", wvalid);
        end
      end
      if (e == 6) begin
        checks++;
        if (wvalid !== 1'b1 || word !== 32'h1234_ABCD) begin
          errs++;
          $display("FAIL clean_edge6: v=%b word=%h want 1 1234abcd", wvalid, word);
        end
      end
    end
  endtask

  task automatic test_scan();
    logic [7:0] exp_an [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                               8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] exp_sg [8] = '{7'h21, 7'h46, 7'h03, 7'h08,
                               7'h19, 7'h30, 7'h24, 7'h79};
    int d;
    data = 32'h0BAD_F00D;
    for (int i = 0; i < 40; i++) begin
      tick();
      cmp_model("scan_model");
      d = -1;
      for (int j = 0; j < 8; j++) if (an == exp_an[j]) d = j;
      checks++;
      if (d < 0 || seg !== exp_sg[d < 0 ? 0 : d]) begin
        errs++;
        $display("FAIL scan_digit: an=%h seg=%h", an, seg);
      end
    end
  endtask

  task automatic test_glitch();
    rst = 1; btn = 0; tick();
    rst = 0; tick(); tick();
    btn = 1; tick(); tick(); tick();
    btn = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cmp_model("glitch_model");
      checks++;
      if (wvalid !== 1'b0 || dut.db_q !== 1'b0) begin
        errs++;
        $display("FAIL glitch: v=%b db=%b want 0 0", wvalid, dut.db_q);
      end
    end
  endtask

  task automatic test_repress();
    logic saw0;
    btn = 1; data = 32'h1234_ABCD;
    for (int i = 0; i < 10; i++) tick();
    btn = 0;
    for (int i = 0; i < 8; i++) tick();
    data = 32'hDEAD_BEEF;
    btn = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      cmp_model("repress_model");
    end
    checks++;
    if (word !== 32'hDEAD_BEEF) begin
      errs++;
      $display("FAIL repress_word: word=%h want deadbeef", word);
    end
    data = 32'h5555_0000;
    saw0 = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (an == 8'hFE) begin
        saw0 = 1;
        checks++;
        if (seg !== 7'h0E) begin
          errs++;
          $display("FAIL repress_digit0: seg=%h want 0e", seg);
        end
      end
    end
    checks++;
    if (word !== 32'hDEAD_BEEF || !saw0) begin
      errs++;
      $display("FAIL hold_no_recapture: word=%h saw0=%b want deadbeef 1", word, saw0);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int n = 0; n < 300; n++) begin
      btn = $urandom_range(0, 1);
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        data = $urandom;
        tick();
        cmp_model("random_model");
      end
    end
  endtask

  task automatic test_mid_reset();
    btn = 0; for (int i = 0; i < 8; i++) tick();
    btn = 1; for (int i = 0; i < 12; i++) tick();
    checks++;
    if (wvalid !== 1'b1) begin
      errs++;
      $display("FAIL midreset_pre: v=%b want 1", wvalid);
    end
    rst = 1;
    tick();
    checks++;
    if (an !== 8'hFF || word !== 32'h0 || wvalid !== 1'b0 ||
        dut.idx_q !== 3'd0) begin
      errs++;
      $display("FAIL midreset: an=%h word=%h v=%b idx=%0d want FF 0 0 0",
               an, word, wvalid, dut.idx_q);
    end
    rst = 0; btn = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      cmp_model("midreset_model");
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_scan();
    test_glitch();
    test_repress();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
